// File: rtl/sha3_pkg.sv
// -----------------------------------------------------------------------------
// sha3_pkg
// Shared constants and types for the SHA3-256 pad/pack front end.
//   RATE_LANES : 64-bit lanes per rate block (1088-bit rate for SHA3-256)
//   LANE_W     : lane width in bits
//   DS_BYTE    : domain-separation pad byte appended after the message
//   END_BYTE   : final pad bit, lands in byte 7 of the last rate lane
//   state_t    : packer FSM states
// -----------------------------------------------------------------------------
package sha3_pkg;

    localparam int          RATE_LANES = 17;
    localparam int          LANE_W     = 64;
    localparam logic [7:0]  DS_BYTE    = 8'h06;
    localparam logic [7:0]  END_BYTE   = 8'h80;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SEND  = 2'd1,
        EXTRA = 2'd2
    } state_t;

    // Byte counts above a full lane are treated as a full lane.
    function automatic logic [3:0] clamp_nbytes(input logic [3:0] n);
        return (n > 4'd8) ? 4'd8 : n;
    endfunction

endpackage

// File: rtl/sha3_lane_pad.sv
// -----------------------------------------------------------------------------
// sha3_lane_pad
// Combinational lane padder. Keeps the low `nbytes` bytes of `word`, zeroes
// the rest and, when `pad_en` is set and there is room, writes DS_BYTE into
// byte position `nbytes`.
//   word    in  64 : little-endian message word
//   nbytes  in  4  : valid bytes, already clamped to 0..8
//   pad_en  in  1  : insert DS_BYTE right after the valid bytes
//   lane    out 64 : masked/padded lane
// -----------------------------------------------------------------------------
module sha3_lane_pad #(
    parameter logic [7:0] DS_BYTE = sha3_pkg::DS_BYTE
) (
    input  logic [63:0] word,
    input  logic [3:0]  nbytes,
    input  logic        pad_en,
    output logic [63:0] lane
);

    always_comb begin
        lane = '0;
        for (int b = 0; b < 8; b++) begin
            if (b < int'(nbytes)) begin
                lane[b*8 +: 8] = word[b*8 +: 8];
            end else if (pad_en && (b == int'(nbytes))) begin
                lane[b*8 +: 8] = DS_BYTE;
            end
        end
    end

endmodule

// File: rtl/sha3_pad_packer.sv
// -----------------------------------------------------------------------------
// sha3_pad_packer
// Collects a message streamed as 64-bit little-endian words into 17-lane rate
// blocks, applies SHA3 domain padding (DS_BYTE ... END_BYTE) and hands each
// block to the SHA3-256 wrapper. One block buffer: input stalls while a block
// is waiting to be accepted.
//   clk, rst_n              : clock, asynchronous active-low reset
//   s_valid/s_ready         : input word handshake
//   s_data                  : message word, byte 0 in bits [7:0]
//   s_last, s_nbytes        : final word flag and its valid byte count (0..8)
//   in_valid/in_ready       : block handshake toward the wrapper
//   in_data_0..in_data_16   : block lanes
//   in_done                 : marks the final block of a message
// -----------------------------------------------------------------------------
module sha3_pad_packer #(
    parameter int         RATE_LANES = sha3_pkg::RATE_LANES,
    parameter logic [7:0] DS_BYTE    = sha3_pkg::DS_BYTE,
    parameter logic [7:0] END_BYTE   = sha3_pkg::END_BYTE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    input  logic [63:0] s_data,
    input  logic        s_last,
    input  logic [3:0]  s_nbytes,
    output logic        s_ready,
    output logic        in_valid,
    output logic [63:0] in_data_0,
    output logic [63:0] in_data_1,
    output logic [63:0] in_data_2,
    output logic [63:0] in_data_3,
    output logic [63:0] in_data_4,
    output logic [63:0] in_data_5,
    output logic [63:0] in_data_6,
    output logic [63:0] in_data_7,
    output logic [63:0] in_data_8,
    output logic [63:0] in_data_9,
    output logic [63:0] in_data_10,
    output logic [63:0] in_data_11,
    output logic [63:0] in_data_12,
    output logic [63:0] in_data_13,
    output logic [63:0] in_data_14,
    output logic [63:0] in_data_15,
    output logic [63:0] in_data_16,
    output logic        in_done,
    input  logic        in_ready
);

    import sha3_pkg::*;

    localparam logic [4:0]  LAST_LANE = 5'(RATE_LANES - 1);
    localparam logic [63:0] END_LANE  = {END_BYTE, 56'h0};

    state_t      state_q, state_d;
    logic [4:0]  lane_cnt_q, lane_cnt_d;
    logic [63:0] buf_q [RATE_LANES];
    logic [63:0] buf_d [RATE_LANES];
    logic        done_q, done_d;
    logic        extra_q, extra_d;
    logic        s_ready_q, s_ready_d;
    logic        in_valid_q, in_valid_d;

    logic        word_acc;
    logic        block_acc;
    logic [3:0]  nbytes_c;
    logic [63:0] pad_cur;
    logic [63:0] pad_next;

    assign word_acc  = s_valid && s_ready_q;
    assign block_acc = in_valid_q && in_ready;
    assign nbytes_c  = clamp_nbytes(s_nbytes);

    // Final word: keep its valid bytes, DS_BYTE follows when the word is short.
    sha3_lane_pad #(.DS_BYTE(DS_BYTE)) u_pad_cur (
        .word   (s_data),
        .nbytes (nbytes_c),
        .pad_en (nbytes_c != 4'd8),
        .lane   (pad_cur)
    );

    // A full final word pushes DS_BYTE into byte 0 of the following lane.
    sha3_lane_pad #(.DS_BYTE(DS_BYTE)) u_pad_next (
        .word   (64'h0),
        .nbytes (4'd0),
        .pad_en (1'b1),
        .lane   (pad_next)
    );

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        done_d     = done_q;
        extra_d    = extra_q;
        buf_d      = buf_q;

        case (state_q)
            FILL: begin
                if (word_acc) begin
                    if (!s_last) begin
                        buf_d[lane_cnt_q] = s_data;
                        if (lane_cnt_q == LAST_LANE) begin
                            state_d    = SEND;
                            done_d     = 1'b0;
                            lane_cnt_d = '0;
                        end else begin
                            lane_cnt_d = lane_cnt_q + 5'd1;
                        end
                    end else begin
                        buf_d[lane_cnt_q] = pad_cur;
                        lane_cnt_d        = '0;
                        state_d           = SEND;
                        if ((nbytes_c == 4'd8) && (lane_cnt_q == LAST_LANE)) begin
                            // Block is exactly full: padding goes into an
                            // extra block generated after this one.
                            extra_d = 1'b1;
                            done_d  = 1'b0;
                        end else begin
                            if (nbytes_c == 4'd8) begin
                                buf_d[lane_cnt_q + 5'd1] = pad_next;
                            end
                            // OR so that DS_BYTE and END_BYTE merge (0x86)
                            // when both fall in the top byte.
                            buf_d[LAST_LANE] = buf_d[LAST_LANE] | END_LANE;
                            done_d           = 1'b1;
                        end
                    end
                end
            end

            SEND: begin
                if (block_acc) begin
                    for (int i = 0; i < RATE_LANES; i++) begin
                        buf_d[i] = '0;
                    end
                    lane_cnt_d = '0;
                    done_d     = 1'b0;
                    extra_d    = 1'b0;
                    state_d    = extra_q ? EXTRA : FILL;
                end
            end

            EXTRA: begin
                for (int i = 0; i < RATE_LANES; i++) begin
                    buf_d[i] = '0;
                end
                buf_d[0]         = {56'h0, DS_BYTE};
                buf_d[LAST_LANE] = END_LANE;
                done_d           = 1'b1;
                state_d          = SEND;
            end

            default: begin
                state_d = FILL;
            end
        endcase

        // Handshake flags follow the next state so they line up with it.
        s_ready_d  = (state_d == FILL);
        in_valid_d = (state_d == SEND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            lane_cnt_q <= '0;
            done_q     <= 1'b0;
            extra_q    <= 1'b0;
            s_ready_q  <= 1'b0;
            in_valid_q <= 1'b0;
            for (int i = 0; i < RATE_LANES; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            done_q     <= done_d;
            extra_q    <= extra_d;
            s_ready_q  <= s_ready_d;
            in_valid_q <= in_valid_d;
            for (int i = 0; i < RATE_LANES; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign s_ready    = s_ready_q;
    assign in_valid   = in_valid_q;
    assign in_done    = done_q;
    assign in_data_0  = buf_q[0];
    assign in_data_1  = buf_q[1];
    assign in_data_2  = buf_q[2];
    assign in_data_3  = buf_q[3];
    assign in_data_4  = buf_q[4];
    assign in_data_5  = buf_q[5];
    assign in_data_6  = buf_q[6];
    assign in_data_7  = buf_q[7];
    assign in_data_8  = buf_q[8];
    assign in_data_9  = buf_q[9];
    assign in_data_10 = buf_q[10];
    assign in_data_11 = buf_q[11];
    assign in_data_12 = buf_q[12];
    assign in_data_13 = buf_q[13];
    assign in_data_14 = buf_q[14];
    assign in_data_15 = buf_q[15];
    assign in_data_16 = buf_q[16];

endmodule

// File: tb/tb_sha3_pad_packer.sv
// -----------------------------------------------------------------------------
// tb_sha3_pad_packer
// Scoreboard bench: each message is padded by a byte-level SHA3 model when it
// is driven, the expected blocks are queued, and every block the DUT hands
// over is popped and compared lane by lane.
// -----------------------------------------------------------------------------
module tb_sha3_pad_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [63:0] s_data = '0;
    logic        s_last = 1'b0;
    logic [3:0]  s_nbytes = '0;
    logic        s_ready;
    logic        in_valid;
    logic        in_done;
    logic        in_ready = 1'b1;
    logic [63:0] lane [17];

    always #5 clk = ~clk;

    sha3_pad_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_nbytes   (s_nbytes),
        .s_ready    (s_ready),
        .in_valid   (in_valid),
        .in_data_0  (lane[0]),
        .in_data_1  (lane[1]),
        .in_data_2  (lane[2]),
        .in_data_3  (lane[3]),
        .in_data_4  (lane[4]),
        .in_data_5  (lane[5]),
        .in_data_6  (lane[6]),
        .in_data_7  (lane[7]),
        .in_data_8  (lane[8]),
        .in_data_9  (lane[9]),
        .in_data_10 (lane[10]),
        .in_data_11 (lane[11]),
        .in_data_12 (lane[12]),
        .in_data_13 (lane[13]),
        .in_data_14 (lane[14]),
        .in_data_15 (lane[15]),
        .in_data_16 (lane[16]),
        .in_done    (in_done),
        .in_ready   (in_ready)
    );

    typedef struct packed {
        logic             done;
        logic [16:0][63:0] l;
    } blk_t;

    blk_t       exp_q [$];
    logic [7:0] msg [$];
    int         n_checks   = 0;
    int         n_pass     = 0;
    int         accepts    = 0;
    int         exp_blocks = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, act, exp);
    endtask

    // Reference padding: msg || 0x06 || 0* || 0x80 up to a multiple of 136 bytes.
    task automatic push_expected(input int len);
        int         total;
        int         idx;
        logic [7:0] b;
        blk_t       e;
        total = (len / 136 + 1) * 136;
        for (int blk = 0; blk < total / 136; blk++) begin
            e = '0;
            e.done = (blk == total / 136 - 1);
            for (int j = 0; j < 136; j++) begin
                idx = blk * 136 + j;
                b = (idx < len) ? msg[idx] : 8'h00;
                if (idx == len)       b = b | 8'h06;
                if (idx == total - 1) b = b | 8'h80;
                e.l[j / 8][(j % 8) * 8 +: 8] = b;
            end
            exp_q.push_back(e);
            exp_blocks++;
        end
    endtask

    always @(negedge clk) begin : monitor
        blk_t e;
        if (rst_n && in_valid && in_ready) begin
            accepts++;
            if (exp_q.size() == 0) begin
                check("unexpected_block", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                for (int i = 0; i < 17; i++)
                    check($sformatf("blk%0d_lane%0d", accepts, i), lane[i], e.l[i]);
                check($sformatf("blk%0d_in_done", accepts), 64'(in_done), 64'(e.done));
            end
        end
    end

    task automatic drive_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int waitc;
        waitc = 0;
        @(negedge clk);
        while (!s_ready && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        if (!s_ready) begin
            check("s_ready_timeout", 64'd0, 64'd1);
            return;
        end
        s_valid  = 1'b1;
        s_data   = d;
        s_last   = last;
        s_nbytes = nb;
        @(posedge clk);
        #1;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        s_nbytes = '0;
        s_data   = '0;
    endtask

    task automatic make_msg(input int len, input bit rnd);
        msg.delete();
        for (int i = 0; i < len; i++)
            msg.push_back(rnd ? 8'($urandom) : 8'hFF);
    endtask

    // big_n: send a full final word with s_nbytes=15 instead of 8.
    task automatic send_msg(input int len, input bit big_n);
        int         nw;
        int         n;
        logic [63:0] d;
        logic        last;
        logic [3:0]  nb;
        push_expected(len);
        nw = (len == 0) ? 1 : (len + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            n = len - 8 * w;
            if (n > 8) n = 8;
            for (int j = 0; j < 8; j++)
                d[j*8 +: 8] = (j < n) ? msg[8*w + j] : 8'hAA;
            last = (w == nw - 1);
            nb = (last && big_n && n == 8) ? 4'hF : 4'(n);
            drive_word(d, last, nb);
        end
        @(negedge clk);
        check($sformatf("latency_len%0d", len), 64'(in_valid), 64'd1);
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] s0, s2, s16;
        logic        sd;
        int          a0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_in_valid", 64'(in_valid), 64'd0);
        check("rst_in_done", 64'(in_done), 64'd0);
        check("rst_lane0", lane[0], 64'd0);
        check("rst_lane16", lane[16], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_s_ready_low", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        check("rel_s_ready_high", 64'(s_ready), 64'd1);

        // Empty message
        make_msg(0, 0);
        send_msg(0, 0);
        wait_drain();

        // "abc"
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        send_msg(3, 0);
        wait_drain();

        // 135 bytes of 0xFF: DS and END share the top byte
        make_msg(135, 0);
        send_msg(135, 0);
        wait_drain();

        // 136 bytes: full block then extra padding block
        make_msg(136, 0);
        send_msg(136, 0);
        wait_drain();

        // Assorted lengths, random content
        make_msg(200, 1); send_msg(200, 0); wait_drain();
        make_msg(64, 1);  send_msg(64, 1);  wait_drain();   // n>8 clamps to 8
        make_msg(128, 1); send_msg(128, 0); wait_drain();   // DS lands in lane 16 byte 0
        make_msg(272, 1); send_msg(272, 1); wait_drain();   // two full blocks + extra

        // Backpressure
        in_ready = 1'b0;
        make_msg(20, 1);
        send_msg(20, 0);
        s0  = lane[0];
        s2  = lane[2];
        s16 = lane[16];
        sd  = in_done;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_lane0", lane[0], s0);
            check("bp_lane2", lane[2], s2);
            check("bp_lane16", lane[16], s16);
            check("bp_in_done", 64'(in_done), 64'(sd));
            check("bp_in_valid", 64'(in_valid), 64'd1);
            check("bp_s_ready", 64'(s_ready), 64'd0);
        end
        a0 = accepts;
        @(posedge clk);
        #1;
        in_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_one_accept", 64'(accepts - a0), 64'd1);
        check("bp_in_valid_drop", 64'(in_valid), 64'd0);

        // Reset in the middle of a message
        make_msg(40, 1);
        for (int w = 0; w < 5; w++)
            drive_word({msg[8*w+7], msg[8*w+6], msg[8*w+5], msg[8*w+4],
                        msg[8*w+3], msg[8*w+2], msg[8*w+1], msg[8*w]}, 1'b0, 4'd8);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_s_ready", 64'(s_ready), 64'd0);
        check("midrst_in_valid", 64'(in_valid), 64'd0);
        check("midrst_in_done", 64'(in_done), 64'd0);
        for (int i = 0; i < 5; i++)
            check($sformatf("midrst_lane%0d", i), lane[i], 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        send_msg(3, 0);
        wait_drain();

        repeat (3) @(negedge clk);
        check("accept_count", 64'(accepts), 64'(exp_blocks));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
